// File: rtl/ntt_pkg.sv
// ntt_pkg: constants shared by the radix-2 NTT butterfly pipeline and its
// reference model.
//   LOGQ     coefficient width in bits
//   Q        prime modulus
//   MODE_DIT forward Cooley-Tukey butterfly select value
//   MODE_DIF inverse Gentleman-Sande butterfly (with halving) select value
//   TWOINV   multiplicative inverse of 2 modulo Q
package ntt_pkg;

    localparam int   LOGQ     = 32'sd17;
    localparam int   Q        = 32'sd65537;
    localparam logic MODE_DIT = 1'b0;
    localparam logic MODE_DIF = 1'b1;
    localparam int   TWOINV   = (Q + 32'sd1) / 32'sd2;

endpackage

// File: rtl/modred_multiplier_v2.sv
// modred_multiplier_v2: combinational modular multiplier, p = (a * b) mod Q.
// Both operands are expected in [0,Q); the result is fully reduced.
//   a, b : LOGQ-bit operands
//   p    : LOGQ-bit reduced product
module modred_multiplier_v2 #(
    parameter int LOGQ = ntt_pkg::LOGQ,
    parameter int Q    = ntt_pkg::Q
) (
    input  logic [LOGQ-1:0] a,
    input  logic [LOGQ-1:0] b,
    output logic [LOGQ-1:0] p
);

    localparam logic [2*LOGQ-1:0] QW = (2*LOGQ)'(Q);

    logic [2*LOGQ-1:0] prod_s;

    // Full-width product followed by reduction by the constant modulus.
    always_comb begin
        prod_s = {{LOGQ{1'b0}}, a} * {{LOGQ{1'b0}}, b};
        p      = LOGQ'(prod_s % QW);
    end

endmodule

// File: rtl/radix_2_ntt_butterfly_pipe.sv
// radix_2_ntt_butterfly_pipe: 3-register-stage radix-2 NTT butterfly with a
// valid/ready handshake on both sides.
//   mode 0 (DIT): A0 = a0 + tf*a1, A1 = a0 - tf*a1            (mod Q)
//   mode 1 (DIF): A0 = (a0 + a1)/2, A1 = ((a0 - a1)*tf)/2     (mod Q)
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is combinational
//   a0, a1, tf, mode    operands, twiddle and butterfly type
//   in_tag / out_tag    opaque sideband tag travelling with the operands
//   out_valid/out_ready output handshake
//   A0, A1              registered butterfly results
module radix_2_ntt_butterfly_pipe #(
    parameter int LOGQ = ntt_pkg::LOGQ,
    parameter int Q    = ntt_pkg::Q,
    parameter int TAGW = 32'sd8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [LOGQ-1:0] a0,
    input  logic [LOGQ-1:0] a1,
    input  logic [LOGQ-1:0] tf,
    input  logic            mode,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [LOGQ-1:0] A0,
    output logic [LOGQ-1:0] A1,
    output logic [TAGW-1:0] out_tag
);

    import ntt_pkg::*;

    localparam logic [LOGQ:0] QE = (LOGQ+1)'(Q);

    // (a + b) mod Q for a, b in [0,Q).
    function automatic logic [LOGQ-1:0] mod_add(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y);
        logic [LOGQ:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QE) begin
            s = s - QE;
        end else begin
            s = s;
        end
        return LOGQ'(s);
    endfunction

    // (a - b) mod Q for a, b in [0,Q).
    function automatic logic [LOGQ-1:0] mod_sub(input logic [LOGQ-1:0] x, input logic [LOGQ-1:0] y);
        logic [LOGQ:0] d;
        if (x >= y) begin
            d = {1'b0, x} - {1'b0, y};
        end else begin
            d = {1'b0, x} + QE - {1'b0, y};
        end
        return LOGQ'(d);
    endfunction

    // x * 2^-1 mod Q: odd values get Q added first so the shift is exact.
    function automatic logic [LOGQ-1:0] halve(input logic [LOGQ-1:0] x);
        logic [LOGQ:0] h;
        if (x[0]) begin
            h = {1'b0, x} + QE;
        end else begin
            h = {1'b0, x};
        end
        return LOGQ'(h >> 1);
    endfunction

    logic            v1_r, v2_r, v3_r;
    logic            load1_s, load2_s, load3_s;

    logic [LOGQ-1:0] x1_s, y1_s;
    logic [LOGQ-1:0] x1_r, y1_r, tf1_r;
    logic            mode1_r;
    logic [TAGW-1:0] tag1_r;

    logic [LOGQ-1:0] p2_s;
    logic [LOGQ-1:0] x2_r, p2_r;
    logic            mode2_r;
    logic [TAGW-1:0] tag2_r;

    logic [LOGQ-1:0] r0_s, r1_s;
    logic [LOGQ-1:0] r0_r, r1_r;
    logic [TAGW-1:0] tag3_r;

    // Stage load enables: a stage loads when it is empty or being drained.
    always_comb begin
        load3_s  = !v3_r || out_ready;
        load2_s  = !v2_r || load3_s;
        load1_s  = !v1_r || load2_s;
        in_ready = load1_s;
    end

    // Stage valid bits; the only state cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            if (load1_s) v1_r <= in_valid;
            if (load2_s) v2_r <= v1_r;
            if (load3_s) v3_r <= v2_r;
        end
    end

    // S1 datapath: DIT passes operands through, DIF forms sum and difference.
    always_comb begin
        x1_s = a0;
        y1_s = a1;
        if (mode == MODE_DIF) begin
            x1_s = mod_add(a0, a1);
            y1_s = mod_sub(a0, a1);
        end else begin
            x1_s = a0;
            y1_s = a1;
        end
    end

    // S2 multiply is tf * y1 in both modes (a1 for DIT, a0-a1 for DIF).
    modred_multiplier_v2 #(
        .LOGQ (LOGQ),
        .Q    (Q)
    ) u_mul (
        .a (y1_r),
        .b (tf1_r),
        .p (p2_s)
    );

    // S3 datapath: DIT add/sub against the product, DIF halves both values.
    always_comb begin
        r0_s = x2_r;
        r1_s = p2_r;
        if (mode2_r == MODE_DIT) begin
            r0_s = mod_add(x2_r, p2_r);
            r1_s = mod_sub(x2_r, p2_r);
        end else begin
            r0_s = halve(x2_r);
            r1_s = halve(p2_r);
        end
    end

    // Stage data registers, not reset; loaded only with valid upstream data.
    always_ff @(posedge clk) begin
        if (load1_s && in_valid) begin
            x1_r    <= x1_s;
            y1_r    <= y1_s;
            tf1_r   <= tf;
            mode1_r <= mode;
            tag1_r  <= in_tag;
        end
        if (load2_s && v1_r) begin
            x2_r    <= x1_r;
            p2_r    <= p2_s;
            mode2_r <= mode1_r;
            tag2_r  <= tag1_r;
        end
        if (load3_s && v2_r) begin
            r0_r    <= r0_s;
            r1_r    <= r1_s;
            tag3_r  <= tag2_r;
        end
    end

    assign out_valid = v3_r;
    assign A0        = r0_r;
    assign A1        = r1_r;
    assign out_tag   = tag3_r;

endmodule

// File: tb/tb_radix_2_ntt_butterfly_pipe.sv
// Self-checking bench for radix_2_ntt_butterfly_pipe: directed vectors plus
// randomized streaming checked against an arithmetic reference model.
module tb_radix_2_ntt_butterfly_pipe;

    localparam int LOGQ = 17;
    localparam int Q    = 65537;
    localparam int TAGW = 8;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] a0, a1, tf;
    logic            mode;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] A0, A1;
    logic [TAGW-1:0] out_tag;

    int vectors;
    int miscompares;

    int exp0_q[$];
    int exp1_q[$];
    int expt_q[$];

    radix_2_ntt_butterfly_pipe #(.LOGQ(LOGQ), .Q(Q), .TAGW(TAGW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .tf        (tf),
        .mode      (mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A0        (A0),
        .A1        (A1),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain modular arithmetic, DIF uses multiplication by 2^-1.
    function automatic void model(input logic m, input longint x0, input longint x1,
                                  input longint w, output int r0, output int r1);
        longint t, s, d;
        if (m == 1'b0) begin
            t  = (w * x1) % Q;
            r0 = int'((x0 + t) % Q);
            r1 = int'((x0 - t + Q) % Q);
        end else begin
            s  = (x0 + x1) % Q;
            d  = (x0 - x1 + Q) % Q;
            r0 = int'((s * ntt_pkg::TWOINV) % Q);
            r1 = int'((((d * w) % Q) * ntt_pkg::TWOINV) % Q);
        end
    endfunction

    function automatic logic [LOGQ-1:0] rnd_operand();
        if ($urandom_range(7, 0) == 0) return LOGQ'(Q - 1);
        return LOGQ'($urandom_range(Q - 1, 0));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [LOGQ-1:0] x0, input logic [LOGQ-1:0] x1,
                         input logic [LOGQ-1:0] w, input logic [TAGW-1:0] tg);
        in_valid = 1'b1;
        mode     = m;
        a0       = x0;
        a1       = x1;
        tf       = w;
        in_tag   = tg;
    endtask

    task automatic push_expected();
        int r0, r1;
        model(mode, longint'(a0), longint'(a1), longint'(tf), r0, r1);
        exp0_q.push_back(r0);
        exp1_q.push_back(r1);
        expt_q.push_back(int'(in_tag));
    endtask

    task automatic check_head(input string name);
        int e0, e1, et;
        vectors++;
        if (exp0_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: unexpected result A0=%0d A1=%0d tag=%0d, none expected", name, A0, A1, out_tag);
        end else begin
            e0 = exp0_q.pop_front();
            e1 = exp1_q.pop_front();
            et = expt_q.pop_front();
            if (int'(A0) !== e0 || int'(A1) !== e1 || int'(out_tag) !== et) begin
                miscompares++;
                $display("FAIL %s: got A0=%0d A1=%0d tag=%0d, want A0=%0d A1=%0d tag=%0d",
                         name, A0, A1, out_tag, e0, e1, et);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        mode = 1'b0; a0 = '0; a1 = '0; tf = '0; in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
        tick();
    endtask

    // One butterfly through an idle pipe: result appears after the third edge.
    task automatic test_single(input string name, input logic m, input int x0, input int x1,
                               input int w, input logic [TAGW-1:0] tg, input int e0, input int e1);
        out_ready = 1'b1;
        drive(m, LOGQ'(x0), LOGQ'(x1), LOGQ'(w), tg);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_in_ready: got %b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL %s_early: out_valid=%b after edge %0d, want 0", name, out_valid, k + 1);
            end
            tick();
        end
        vectors++;
        if (out_valid !== 1'b1 || int'(A0) !== e0 || int'(A1) !== e1 || out_tag !== tg) begin
            miscompares++;
            $display("FAIL %s: got v=%b A0=%0d A1=%0d tag=%0d, want v=1 A0=%0d A1=%0d tag=%0d",
                     name, out_valid, A0, A1, out_tag, e0, e1, tg);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_drain: out_valid=%b want 0", name, out_valid);
        end
    endtask

    task automatic test_dit_basic();
        test_single("dit_basic", 1'b0, 1, 2, 3, 8'h11, 7, 65532);
    endtask

    task automatic test_dit_boundary();
        test_single("dit_boundary", 1'b0, 65536, 65536, 65536, 8'h22, 0, 65535);
    endtask

    task automatic test_dif_halving();
        test_single("dif_odd", 1'b1, 1, 0, 1, 8'h33, 32769, 32769);
        test_single("dif_even", 1'b1, 5, 3, 4, 8'h44, 4, 4);
        test_single("dif_boundary", 1'b1, 65536, 65536, 65536, 8'h55, 65536, 0);
    endtask

    task automatic test_backpressure();
        logic [LOGQ-1:0] h0, h1;
        logic [TAGW-1:0] ht;
        int  idx, got, cyc;
        logic ifire;
        exp0_q.delete(); exp1_q.delete(); expt_q.delete();
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 4; i++) begin
            drive($urandom_range(1, 0) == 1, rnd_operand(), rnd_operand(), rnd_operand(), TAGW'(8'h80 + idx));
            #1;
            ifire = in_ready;
            if (ifire) push_expected();
            tick();
            if (ifire) idx++;
        end
        #1;
        vectors++;
        if (idx !== 3 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: accepted=%0d in_ready=%b out_valid=%b, want 3/0/1", idx, in_ready, out_valid);
        end
        h0 = A0; h1 = A1; ht = out_tag;
        vectors++;
        if (exp0_q.size() == 0 || int'(h0) !== exp0_q[0] || int'(h1) !== exp1_q[0]) begin
            miscompares++;
            $display("FAIL bp_head: got A0=%0d A1=%0d, want first queued result", h0, h1);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || A0 !== h0 || A1 !== h1 || out_tag !== ht) begin
                miscompares++;
                $display("FAIL bp_hold: got v=%b rdy=%b A0=%0d A1=%0d tag=%0d, want 1/0/%0d/%0d/%0d",
                         out_valid, in_ready, A0, A1, out_tag, h0, h1, ht);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 20) begin
            ifire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_head("bp_drain");
                got++;
            end
            if (ifire) push_expected();
            tick();
            if (ifire) in_valid = 1'b0;
            #1;
            cyc++;
        end
        vectors++;
        if (got !== 4) begin
            miscompares++;
            $display("FAIL bp_count: got %0d results want 4", got);
        end
    endtask

    task automatic test_streaming();
        int sent, got, cyc;
        logic ifire;
        exp0_q.delete(); exp1_q.delete(); expt_q.delete();
        in_valid = 1'b0;
        sent = 0; got = 0; cyc = 0;
        while (got < 100 && cyc < 3000) begin
            if (!in_valid && sent < 100 && $urandom_range(3, 0) != 0) begin
                drive($urandom_range(1, 0) == 1, rnd_operand(), rnd_operand(), rnd_operand(),
                      TAGW'(sent));
            end
            out_ready = ($urandom_range(3, 0) != 0);
            #1;
            ifire = in_valid && in_ready;
            if (out_valid && out_ready) begin
                check_head("stream");
                got++;
            end
            if (ifire) begin
                push_expected();
                sent++;
            end
            tick();
            if (ifire) in_valid = 1'b0;
            cyc++;
        end
        vectors++;
        if (got !== 100 || exp0_q.size() != 0) begin
            miscompares++;
            $display("FAIL stream_count: got %0d results, %0d pending, want 100/0", got, exp0_q.size());
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_midflight();
        int e0, e1;
        logic [LOGQ-1:0] x0, x1, w;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'(i), rnd_operand(), rnd_operand(), rnd_operand(), TAGW'(8'hC0 + i));
            tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_async: out_valid=%b want 0", out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_ready: in_ready=%b want 1", in_ready);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid_stale: out_valid=%b tag=%0d at cycle %0d, want 0", out_valid, out_tag, k);
            end
        end
        x0 = rnd_operand(); x1 = rnd_operand(); w = rnd_operand();
        model(1'b1, longint'(x0), longint'(x1), longint'(w), e0, e1);
        test_single("post_reset", 1'b1, int'(x0), int'(x1), int'(w), 8'h5A, e0, e1);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_dit_basic();
        test_dit_boundary();
        test_dif_halving();
        test_backpressure();
        test_streaming();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/radix_2_ntt_butterfly_pipe.md
RADIX_2_NTT_BUTTERFLY_PIPE -- requirements
Module: radix_2_ntt_butterfly_pipe

Interface
REQ-001 SHALL have parameter LOGQ, default 17, meaning the coefficient width in bits.
REQ-002 SHALL have parameter Q, default 65537, meaning the prime modulus.
REQ-003 SHALL have parameter TAGW, default 8, meaning the width of the sideband tag carried alongside each butterfly.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state is rising-edge triggered.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: the input operand set is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the operand set this cycle.
REQ-008 SHALL have ports a0, a1 and tf, each input, LOGQ bits: the butterfly operands and the twiddle factor, each in [0,Q).
REQ-009 SHALL have port mode, input, 1 bit, sampled with the operands: 0 selects a DIT/Cooley-Tukey forward butterfly, 1 selects a DIF/Gentleman-Sande inverse butterfly with halving.
REQ-010 SHALL have port in_tag, input, TAGW bits: an opaque sideband tag.
REQ-011 SHALL have port out_valid, output, 1 bit: the result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the result.
REQ-013 SHALL have ports A0 and A1, each output, LOGQ bits: the butterfly results, each in [0,Q).
REQ-014 SHALL have port out_tag, output, TAGW bits: the tag that entered with the operands.

Function
REQ-015 In mode 0, SHALL compute A0 = (a0 + tf*a1) mod Q and A1 = (a0 - tf*a1) mod Q.
REQ-016 In mode 1, SHALL compute A0 = (a0 + a1)*2^-1 mod Q and A1 = ((a0 - a1)*tf)*2^-1 mod Q.
REQ-017 SHALL implement halving without a multiplier: x even gives x>>1; x odd gives (x+Q)>>1, using a LOGQ+1-bit intermediate.
REQ-018 SHALL be a 3-stage pipeline with latency exactly 3 cycles from the accepting edge to the edge on which out_valid rises, given no stall.
- Mode 0 stages: S1 registers the operands; S2 performs the modular multiply; S3 performs the modular add and subtract.
- Mode 1 stages: S1 performs the modular add and subtract; S2 performs the modular multiply of the difference (the sum passes through); S3 halves both values.
REQ-019 SHALL carry mode and tag through every stage with the data, so that mixed-mode back-to-back inputs each produce their own correct result.
REQ-020 SHALL reduce every add, subtract and multiply result fully into [0,Q); an input equal to Q-1 on every port SHALL NOT overflow.
REQ-021 Handshake: a transfer occurs on an edge where valid && ready.
- Each stage advances when its downstream register is empty or is being emptied on the same edge.
- in_ready SHALL be combinational: !S1_valid || S1 advances.
REQ-022 When out_valid=1 and out_ready=0, SHALL hold A0, A1 and out_tag stable, and SHALL NOT drop out_valid until the transfer occurs.
REQ-023 SHALL sustain one butterfly per cycle when in_valid and out_ready are held high continuously.
REQ-024 With 3 results held under backpressure, SHALL drive in_ready=0; an input offered while in_ready=0 SHALL NOT be accepted or lost.
REQ-025 When out_ready rises in the same cycle a new input is offered to a full pipeline, SHALL emit the head result and accept the new input on the same edge.
REQ-026 Stage data registers SHALL NOT be reset; only the stage valid bits are reset.

Reset
REQ-027 While rst_n=0, SHALL clear all stage valid bits asynchronously, giving out_valid=0 and in_ready=1 after reset is released.
REQ-028 A reset asserted mid-operation SHALL discard all in-flight butterflies; no result from before the reset SHALL appear after it.
REQ-029 The first input accepted after reset release SHALL produce its result exactly 3 cycles later.

Structure
REQ-030 The shared package ntt_pkg SHALL define LOGQ, Q, the mode encodings MODE_DIT=0 and MODE_DIF=1, and the constant TWOINV=(Q+1)/2 for use by the reference model.
REQ-031 SHALL instantiate exactly one sub-module, modred_multiplier_v2, for the S2 multiply; S1 and S3 SHALL use inline add/sub reduction or modred_adder.

Verification
REQ-032 DIT basic: mode=0, a0=1, a1=2, tf=3 -> A0=7, A1=65532, three cycles after acceptance.
REQ-033 DIT boundary: mode=0, a0=a1=tf=65536 -> A0=0, A1=65535.
REQ-034 DIF with odd halving: mode=1, a0=1, a1=0, tf=1 -> A0=32769, A1=32769; mode=1, a0=5, a1=3, tf=4 -> A0=4, A1=4.
REQ-035 Backpressure: out_ready=0 while 4 inputs are offered on consecutive cycles -> 3 accepted, in_ready=0, outputs stable; then out_ready=1 -> 4 results in order with matching tags.
REQ-036 Streaming: 100 random mixed-mode inputs with random in_valid and out_ready -> every result matches the golden model, in order, with no drops or duplicates.
REQ-037 Reset mid-flight: rst_n=0 for 1 cycle with 3 butterflies in flight -> out_valid=0 immediately and no stale outputs afterwards.
